// File: rtl/axis_pkg.sv
// Shared AXI-Stream unpacker types: default widths, derived lane count, lane/beat/keep types
// and the holding-register state encoding.
package axis_pkg;

    localparam int DEFAULT_WORD_W = 8;
    localparam int DEFAULT_BUS_W  = 32;

    function automatic int words_per_beat(input int bus_w, input int word_w);
        return bus_w / word_w;
    endfunction

    localparam int WORDS_PER_BEAT = words_per_beat(DEFAULT_BUS_W, DEFAULT_WORD_W);

    typedef logic [DEFAULT_WORD_W-1:0]              word_t;
    typedef word_t [WORDS_PER_BEAT-1:0]             beat_t;
    typedef logic [WORDS_PER_BEAT-1:0]              keep_t;

    // EMPTY: no lanes left in the holding register; HOLD: at least one lane still to emit.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/axis_unpacker_if.sv
// Handshake bundle for axis_unpacker: lane-packed beat input side and single-word output side.
interface axis_unpacker_if
    import axis_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W,
    parameter int LANES  = WORDS_PER_BEAT
);
    logic                        s_valid;
    logic                        s_ready;
    logic [LANES-1:0][WORD_W-1:0] s_data;
    logic [LANES-1:0]            s_keep;
    logic                        s_last;

    logic                        m_valid;
    logic                        m_ready;
    logic [WORD_W-1:0]           m_data;
    logic                        m_last;

    // slave: the unpacker itself; master: whoever feeds beats and takes words.
    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/axis_unpacker_lane_pick.sv
// axis_lane_pick: lowest-set-bit priority encoder with any-set and exactly-one-set flags.
module axis_lane_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             one_o
);

    // NOTE: idx_o gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        idx_o = '0;
        // Scanning downward lets the lowest set bit be the last (winning) assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |mask_i;
    assign one_o = any_o && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/axis_unpacker.sv
// AXI-Stream beat-to-word unpacker: emits kept lanes lowest-first, one word per handshake.
// Optional empty-beat checker enabled by defining AXIS_UNPACKER_KEEP_CHECK_EN.
module axis_unpacker
    import axis_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W,
    parameter int BUS_W  = DEFAULT_BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    axis_unpacker_if.slave   bus,
    output logic             keep_err
);

    localparam int LANES = words_per_beat(BUS_W, WORD_W);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0][WORD_W-1:0] beat_data_q, beat_data_d;
    logic [LANES-1:0]             rem_mask_q, rem_mask_d;
    logic                         beat_last_q, beat_last_d;

    logic [IDX_W-1:0] lane;
    logic             mask_any;
    logic             mask_one;
    logic             s_ready_w;
    logic             accept;
    state_e           state_w;

    axis_lane_pick #(
        .N     (LANES),
        .IDX_W (IDX_W)
    ) u_lane_pick (
        .mask_i (rem_mask_q),
        .idx_o  (lane),
        .any_o  (mask_any),
        .one_o  (mask_one)
    );

    assign state_w = mask_any ? ST_HOLD : ST_EMPTY;

    always_comb begin
        rem_mask_d  = rem_mask_q;
        beat_data_d = beat_data_q;
        beat_last_d = beat_last_q;
        s_ready_w   = 1'b0;

        case (state_w)
            ST_EMPTY: s_ready_w = !rst;
            ST_HOLD: begin
                // Ready on the final word's handshake so the next beat loads without a bubble.
                s_ready_w = !rst && bus.m_ready && mask_one;
                if (bus.m_ready) begin
                    rem_mask_d[lane] = 1'b0;
                end
            end
            default: s_ready_w = 1'b0;
        endcase

        // A new beat overrides the final-lane clear taken above.
        if (bus.s_valid && s_ready_w) begin
            beat_data_d = bus.s_data;
            rem_mask_d  = bus.s_keep;
            beat_last_d = bus.s_last;
        end
    end

    assign accept      = bus.s_valid && s_ready_w;
    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = mask_any;
    assign bus.m_data  = beat_data_q[lane];
    assign bus.m_last  = beat_last_q && mask_one;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_mask_q  <= '0;
            beat_data_q <= '0;
            beat_last_q <= 1'b0;
        end else begin
            rem_mask_q  <= rem_mask_d;
            beat_data_q <= beat_data_d;
            beat_last_q <= beat_last_d;
        end
    end

`ifdef AXIS_UNPACKER_KEEP_CHECK_EN
    logic keep_err_q, keep_err_d;
    logic pkt_start_q;

    // Flags an empty beat that closes a packet (its m_last is lost) or opens one.
    assign keep_err_d = accept && (bus.s_keep == '0) && (bus.s_last || pkt_start_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            keep_err_q  <= 1'b0;
            pkt_start_q <= 1'b1;  // reset counts as a packet boundary
        end else begin
            keep_err_q <= keep_err_d;
            if (accept) begin
                pkt_start_q <= bus.s_last;
            end
        end
    end

    assign keep_err = keep_err_q;
`else
    assign keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_unpacker.sv
// Directed and packet-stream bench for axis_unpacker (WORD_W=8, BUS_W=32).
module tb_axis_unpacker;

    logic clk;
    logic rst;
    logic keep_err;
    int   checks;
    int   failures;

    axis_unpacker_if bus ();

    axis_unpacker u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .keep_err (keep_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_keep  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready);
        end
        checks++;
        if ({bus.m_valid, bus.m_last} !== 2'b00) begin
            failures++; $display("FAIL reset_m_valid_last got=%b%b exp=00", bus.m_valid, bus.m_last);
        end
        checks++;
        if (bus.m_data !== 8'h00) begin
            failures++; $display("FAIL reset_m_data got=%h exp=00", bus.m_data);
        end
        checks++;
        if (keep_err !== 1'b0) begin
            failures++; $display("FAIL reset_keep_err got=%b exp=0", keep_err);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_s_ready got=%b exp=1", bus.s_ready);
        end
    endtask

    task automatic test_single_beat();
        logic [7:0] exp_w [4];
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h44332211;
        bus.s_keep  = 4'b1111;
        bus.s_last  = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL single_s_ready_idle got=%b exp=1", bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, exp_w[k], k == 3}) begin
                failures++;
                $display("FAIL single_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp_w[k], k == 3);
            end
            checks++;
            if (bus.s_ready !== (k == 3)) begin
                failures++; $display("FAIL single_s_ready%0d got=%b exp=%b", k, bus.s_ready, k == 3);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL single_drain got=%b exp=0", bus.m_valid);
        end
    endtask

    task automatic test_sparse_keep();
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDDCCBBAA;
        bus.s_keep  = 4'b1010;
        bus.s_last  = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'hBB, 1'b0}) begin
            failures++;
            $display("FAIL sparse_word0 got v=%b d=%h l=%b exp v=1 d=bb l=0", bus.m_valid, bus.m_data, bus.m_last);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'hDD, 1'b1}) begin
            failures++;
            $display("FAIL sparse_word1 got v=%b d=%h l=%b exp v=1 d=dd l=1", bus.m_valid, bus.m_data, bus.m_last);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL sparse_drain got=%b exp=0", bus.m_valid);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h04030201;
        bus.s_keep  = 4'b1111;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        bus.s_data  = 32'h08070605;
        bus.s_last  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'(k + 1), k == 7}) begin
                failures++;
                $display("FAIL b2b_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, 8'(k + 1), k == 7);
            end
            tick();
            if (k == 3) bus.s_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drain got=%b exp=0", bus.m_valid);
        end
    endtask

    task automatic test_empty_last();
        logic exp_err;
`ifdef AXIS_UNPACKER_KEEP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEADBEEF;
        bus.s_keep  = 4'b0000;
        bus.s_last  = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL empty_s_ready got=%b exp=1", bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL empty_m_valid got=%b exp=0", bus.m_valid);
        end
        checks++;
        if (keep_err !== exp_err) begin
            failures++; $display("FAIL empty_keep_err got=%b exp=%b", keep_err, exp_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.m_valid, keep_err} !== 2'b00) begin
            failures++; $display("FAIL empty_after got v=%b err=%b exp v=0 err=0", bus.m_valid, keep_err);
        end
    endtask

    task automatic test_reset_mid_beat();
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h44332211;
        bus.s_keep  = 4'b1111;
        bus.s_last  = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_data !== 8'h11) begin
            failures++; $display("FAIL midrst_word0 got=%h exp=11", bus.m_data);
        end
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_s_ready_in_reset got=%b exp=0", bus.s_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_valid, bus.m_data} !== 9'h000) begin
            failures++; $display("FAIL midrst_cleared got v=%b d=%h exp v=0 d=00", bus.m_valid, bus.m_data);
        end
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_s_ready_after got=%b exp=1", bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h000000AA;
        bus.s_keep  = 4'b0001;
        bus.s_last  = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'hAA, 1'b1}) begin
            failures++;
            $display("FAIL midrst_new_pkt got v=%b d=%h l=%b exp v=1 d=aa l=1", bus.m_valid, bus.m_data, bus.m_last);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_drain got=%b exp=0", bus.m_valid);
        end
    endtask

    task automatic test_random_packets();
        logic [31:0] beat_q [$];
        logic [3:0]  keep_q [$];
        logic        last_q [$];
        logic [7:0]  exp_d  [$];
        logic        exp_l  [$];
        int          total;

        for (int p = 0; p < 20; p++) begin
            int rem;
            rem = $urandom_range(1, 100);
            while (rem > 0) begin
                logic [31:0] d;
                logic [3:0]  kp;
                d  = $urandom;
                kp = 4'($urandom_range(1, 15));
                for (int ln = 0; ln < 4; ln++) begin
                    if (kp[ln]) begin
                        if (rem > 0) begin
                            d[ln*8 +: 8] = 8'($urandom_range(0, 255));
                            exp_d.push_back(d[ln*8 +: 8]);
                            rem--;
                            exp_l.push_back(rem == 0);
                        end else begin
                            kp[ln] = 1'b0;
                        end
                    end
                end
                beat_q.push_back(d);
                keep_q.push_back(kp);
                last_q.push_back(rem == 0);
            end
        end
        total = exp_d.size();

        tick();
        fork
            begin : driver
                int cyc;
                cyc = 0;
                for (int b = 0; b < beat_q.size(); b++) begin
                    logic rdy;
                    bus.s_valid = 1'b1;
                    bus.s_data  = beat_q[b];
                    bus.s_keep  = keep_q[b];
                    bus.s_last  = last_q[b];
                    rdy = 1'b0;
                    while (!rdy && cyc < 60000) begin
                        @(negedge clk);
                        rdy = bus.s_ready;
                        tick();
                        cyc++;
                    end
                    if (!rdy) begin
                        checks++;
                        failures++;
                        $display("FAIL rand_driver_timeout beat=%0d of %0d", b, beat_q.size());
                        break;
                    end
                end
                bus.s_valid = 1'b0;
            end
            begin : monitor
                int   got;
                int   cyc;
                logic prev_stall;
                logic [8:0] prev_out;
                got        = 0;
                cyc        = 0;
                prev_stall = 1'b0;
                prev_out   = '0;
                while (got < total && cyc < 60000) begin
                    bus.m_ready = ($urandom_range(0, 9) == 0);
                    @(negedge clk);
                    cyc++;
                    if (prev_stall) begin
                        checks++;
                        if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, prev_out}) begin
                            failures++;
                            $display("FAIL rand_stall_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                     bus.m_valid, bus.m_data, bus.m_last, prev_out[8:1], prev_out[0]);
                        end
                    end
                    if (bus.m_valid && bus.m_ready) begin
                        checks++;
                        if ({bus.m_data, bus.m_last} !== {exp_d[got], exp_l[got]}) begin
                            failures++;
                            $display("FAIL rand_word%0d got d=%h l=%b exp d=%h l=%b",
                                     got, bus.m_data, bus.m_last, exp_d[got], exp_l[got]);
                        end
                        got++;
                    end
                    prev_stall = bus.m_valid && !bus.m_ready;
                    prev_out   = {bus.m_data, bus.m_last};
                    tick();
                end
                checks++;
                if (got != total) begin
                    failures++; $display("FAIL rand_word_count got=%0d exp=%0d", got, total);
                end
            end
        join
        bus.m_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL rand_drain got=%b exp=0", bus.m_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_beat();
        test_sparse_keep();
        test_back_to_back();
        test_empty_last();
        test_reset_mid_beat();
        test_random_packets();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
